clk_div_multi: RTL

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 90 +++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free, period-aligned divisor/mode updates.
// Each channel counts 0..act_div and produces a 50% toggle clock or a one-cycle pulse.
module clk_div_multi #(
    parameter int WIDTH = 11,
    parameter int NCH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         mode,
    input  logic [NCH*WIDTH-1:0]   div,
    input  logic                   load,
    output logic [NCH-1:0]         clkd,
    output logic [NCH-1:0]         tick,
    output logic [NCH-1:0]         busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q        [NCH];
    logic [WIDTH-1:0] act_div  [NCH];
    logic [WIDTH-1:0] pend_div [NCH];
    logic [WIDTH-1:0] div_sl   [NCH];
    logic [NCH-1:0]   act_mode;
    logic [NCH-1:0]   pend_mode;
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   tc;
    logic [NCH-1:0]   apply;

    // Pending values land only at a period boundary or while the channel is idle.
    always_comb begin
        tc    = '0;
        apply = '0;
        for (int i = 0; i < NCH; i++) begin
            div_sl[i] = div[i*WIDTH +: WIDTH];
            tc[i]     = en[i] && (q[i] == act_div[i]);
            apply[i]  = pend[i] && (tc[i] || !en[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                q[i]        <= '0;
                act_div[i]  <= '0;
                pend_div[i] <= '0;
            end
            act_mode  <= '0;
            pend_mode <= '0;
            pend      <= '0;
            clkd      <= '0;
            tick      <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (apply[i]) begin
                    act_div[i]  <= pend_div[i];
                    act_mode[i] <= pend_mode[i];
                end

                // A load on the applying edge re-arms pend with the fresh values.
                if (load) begin
                    pend_div[i]  <= div_sl[i];
                    pend_mode[i] <= mode[i];
                    pend[i]      <= 1'b1;
                end else if (apply[i]) begin
                    pend[i] <= 1'b0;
                end

                if (!en[i] || tc[i])
                    q[i] <= '0;
                else
                    q[i] <= q[i] + ONE;

                tick[i] <= tc[i];

                if (!en[i])
                    clkd[i] <= 1'b0;
                else if (apply[i] && (pend_mode[i] != act_mode[i]))
                    clkd[i] <= 1'b0;
                else if (tc[i])
                    clkd[i] <= act_mode[i] ? 1'b1 : ~clkd[i];
                else if (act_mode[i])
                    clkd[i] <= 1'b0;
            end
        end
    end

    assign busy = pend;

endmodule
